// File: rtl/arb_pkg.sv
// Shared types and sizes for the 32-way round-robin arbiter.
package arb_pkg;

    localparam int N     = 32;
    localparam int IDX_W = 5;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef logic [IDX_W-1:0] arb_idx_t;

endpackage

// File: rtl/decoder_5_to_32.sv
// 5-to-32 one-hot decoder with enable; all outputs low when disabled.
module decoder_5_to_32 (
    input  logic        ena,
    input  logic [4:0]  in,
    output logic [31:0] out
);

    always_comb begin
        out = '0;
        if (ena) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_32.sv
// Round-robin arbiter for 32 requesters with held grants, forced revocation
// after MAX_HOLD cycles and a registered grant index plus one-hot grant bus.
module rr_arbiter_32
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [31:0] req,
    input  logic        release_i,
    output logic        grant_valid,
    output logic [4:0]  grant_idx,
    output logic [31:0] grant_onehot,
    output logic        timeout
);

    localparam int                 HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state;
    arb_state_t        next_state;
    arb_idx_t          ptr;
    arb_idx_t          sel_idx;
    logic              found;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_expired;
    logic              end_other;
    logic              end_grant;

    // Scan ptr, ptr+1, ... with 5-bit wrap; the first set request wins.
    always_comb begin
        found   = 1'b0;
        sel_idx = ptr;
        for (int i = 0; i < N; i++) begin
            if (!found && req[ptr + arb_idx_t'(i)]) begin
                found   = 1'b1;
                sel_idx = ptr + arb_idx_t'(i);
            end
        end
    end

    always_comb begin
        hold_expired = (hold_cnt == HOLD_LAST);
        end_other    = release_i || !req[grant_idx] || !ena;
        end_grant    = end_other || hold_expired;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ena && found) next_state = GRANT;
            GRANT:   if (end_grant)    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Timeout is reported only when the hold limit alone ended the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            hold_cnt    <= '0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (ena && found) begin
                        grant_idx   <= sel_idx;
                        grant_valid <= 1'b1;
                        hold_cnt    <= '0;
                    end
                end
                GRANT: begin
                    if (end_grant) begin
                        grant_valid <= 1'b0;
                        ptr         <= grant_idx + arb_idx_t'(1);
                        timeout     <= hold_expired && !end_other;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: grant_valid <= 1'b0;
            endcase
        end
    end

    decoder_5_to_32 u_decoder (
        .ena (grant_valid),
        .in  (grant_idx),
        .out (grant_onehot)
    );

endmodule

// File: tb/tb_rr_arbiter_32.sv
// Scoreboard bench for rr_arbiter_32: directed phases push expected grants,
// timeouts and snapshots; a negedge monitor pops and compares them.
module tb_rr_arbiter_32;

    localparam int EV_GRANT   = 1;
    localparam int EV_TIMEOUT = 2;

    typedef struct {
        int       kind;
        logic [4:0] idx;
        int       dur;
    } ev_t;

    typedef struct {
        logic       valid;
        logic [4:0] idx;
        logic       tmo;
        bit         last;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [31:0] req;
    logic        release_i;
    logic        grant_valid;
    logic [4:0]  grant_idx;
    logic [31:0] grant_onehot;
    logic        timeout;

    ev_t   exp_q[$];
    snap_t snap_q[$];

    int checks = 0;
    int errors = 0;
    bit mon_done = 0;

    logic prev_valid = 1'b0;
    int   run_len = 0;
    int   cur_dur = 0;

    rr_arbiter_32 #(.MAX_HOLD(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .req          (req),
        .release_i    (release_i),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [31:0] r, input logic rel, input int n);
        ena       = e;
        req       = r;
        release_i = rel;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushGrant(input logic [4:0] idx, input int dur);
        ev_t e;
        e.kind = EV_GRANT;
        e.idx  = idx;
        e.dur  = dur;
        exp_q.push_back(e);
    endtask

    task automatic pushTimeout();
        ev_t e;
        e.kind = EV_TIMEOUT;
        e.idx  = '0;
        e.dur  = 0;
        exp_q.push_back(e);
    endtask

    task automatic pushSnap(input logic v, input logic [4:0] idx, input logic tmo, input bit last);
        snap_t s;
        s.valid = v;
        s.idx   = idx;
        s.tmo   = tmo;
        s.last  = last;
        snap_q.push_back(s);
    endtask

    // Monitor: every negedge checks the decode invariant and consumes any events.
    always @(negedge clk) begin
        ev_t   e;
        snap_t s;
        checkOutput("onehot_decode", grant_onehot, grant_valid ? (32'd1 << grant_idx) : 32'd0);
        checkOutput("onehot_single", 32'($countones(grant_onehot) <= 1), 32'd1);

        if (!grant_valid && prev_valid && cur_dur != 0) begin
            checkOutput("grant_len", run_len, cur_dur);
        end

        if (grant_valid && !prev_valid) begin
            run_len = 1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                cur_dur = 0;
                $display("[TB] FAIL unexpected_grant: got idx %0d, expected no grant at %0t", grant_idx, $time);
            end else begin
                e = exp_q.pop_front();
                checkOutput("event_kind", EV_GRANT, e.kind);
                checkOutput("grant_idx", grant_idx, e.idx);
                cur_dur = e.dur;
            end
        end else if (grant_valid) begin
            run_len++;
        end

        if (timeout === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_timeout: got 1, expected 0 at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                checkOutput("event_kind", EV_TIMEOUT, e.kind);
            end
        end

        if (snap_q.size() != 0) begin
            s = snap_q.pop_front();
            checkOutput("snap_valid", grant_valid, s.valid);
            checkOutput("snap_idx", grant_idx, s.idx);
            checkOutput("snap_onehot", grant_onehot, s.valid ? (32'd1 << s.idx) : 32'd0);
            checkOutput("snap_timeout", timeout, s.tmo);
            if (s.last) begin
                checkOutput("pending_events", exp_q.size(), 0);
                mon_done = 1;
            end
        end

        prev_valid = grant_valid;
    end

    initial begin
        rst       = 1'b0;
        ena       = 1'b0;
        req       = '0;
        release_i = 1'b0;
        #1;

        // Reset with every request high: outputs must stay cleared.
        rst = 1'b1;
        ena = 1'b1;
        req = '1;
        pushSnap(1'b0, 5'd0, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pushGrant(5'd0, 1);
        applyStimulus(1'b1, '1, 1'b1, 1);
        applyStimulus(1'b1, '0, 1'b1, 3);

        // Rotation from a fresh pointer: 0,1,4,0.
        rst = 1'b1;
        applyStimulus(1'b1, '0, 1'b1, 1);
        rst = 1'b0;
        pushGrant(5'd0, 1);
        pushGrant(5'd1, 1);
        pushGrant(5'd4, 1);
        pushGrant(5'd0, 1);
        applyStimulus(1'b1, 32'h0000_0013, 1'b1, 8);
        applyStimulus(1'b1, '0, 1'b1, 2);

        // Wrap: 5 moves ptr to 6, then 31, wrap to 2, then 31 again.
        pushGrant(5'd5, 1);
        pushGrant(5'd31, 1);
        pushGrant(5'd2, 1);
        pushGrant(5'd31, 1);
        applyStimulus(1'b1, 32'h0000_0020, 1'b1, 2);
        applyStimulus(1'b1, 32'h8000_0004, 1'b1, 6);
        applyStimulus(1'b1, '0, 1'b1, 2);

        // Timeout on a lone requester 7, then regrant and drop the request.
        pushGrant(5'd7, 16);
        pushTimeout();
        pushGrant(5'd7, 1);
        applyStimulus(1'b1, 32'h0000_0080, 1'b0, 18);
        applyStimulus(1'b1, '0, 1'b0, 1);
        pushSnap(1'b0, 5'd7, 1'b0, 0);
        applyStimulus(1'b1, '0, 1'b0, 2);

        // Disabled arbiter ignores requests; then ena drops mid-grant.
        applyStimulus(1'b0, '1, 1'b0, 4);
        pushSnap(1'b0, 5'd7, 1'b0, 0);
        applyStimulus(1'b0, '1, 1'b0, 1);
        pushGrant(5'd8, 1);
        applyStimulus(1'b1, '1, 1'b0, 1);
        applyStimulus(1'b0, '1, 1'b0, 2);

        // Async reset between edges mid-grant, then restart from requester 0.
        pushGrant(5'd9, 0);
        applyStimulus(1'b1, '1, 1'b0, 3);
        #1;
        rst = 1'b1;
        pushSnap(1'b0, 5'd0, 1'b0, 0);
        applyStimulus(1'b1, '1, 1'b0, 1);
        rst = 1'b0;
        pushGrant(5'd3, 1);
        applyStimulus(1'b1, 32'h0010_0008, 1'b1, 1);
        applyStimulus(1'b1, '0, 1'b1, 3);

        pushSnap(1'b0, 5'd3, 1'b0, 1);
        for (int i = 0; i < 20 && !mon_done; i++) begin
            @(posedge clk);
        end
        if (!mon_done) begin
            $display("[TB] FAIL monitor_done: got 0, expected 1 within 20 cycles");
            $fatal(1, "[TB] monitor did not finish");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
